// File: rtl/peripheral_dbg_soc_osd_timestamp_pkg.sv
// Shared types and defaults for the debug timestamp controller slice.
package peripheral_dbg_soc_osd_timestamp_pkg;

   localparam int unsigned DEF_WIDTH      = 16;
   localparam int unsigned DEF_NREQ       = 4;
   localparam int unsigned DEF_PRESCALE_W = 8;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      STOP  = 2'd1,
      RUN   = 2'd2
   } ts_ctrl_state_t;

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/peripheral_dbg_soc_osd_timestamp_ctrl_if.sv
// Snapshot request/response bus between trace requesters and the timestamp controller.
interface peripheral_dbg_soc_osd_timestamp_ctrl_if #(
   parameter int unsigned WIDTH = peripheral_dbg_soc_osd_timestamp_pkg::DEF_WIDTH,
   parameter int unsigned NREQ  = peripheral_dbg_soc_osd_timestamp_pkg::DEF_NREQ
);
   localparam int unsigned ID_W = peripheral_dbg_soc_osd_timestamp_pkg::idx_w(NREQ);

   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   logic             snap_valid;
   logic             snap_ready;
   logic [ID_W-1:0]  snap_id;
   logic [WIDTH-1:0] snap_ts;

   modport master (
      input  req_valid, snap_ready,
      output req_ready, snap_valid, snap_id, snap_ts
   );

   modport slave (
      output req_valid, snap_ready,
      input  req_ready, snap_valid, snap_id, snap_ts
   );

endinterface

// File: rtl/peripheral_dbg_soc_osd_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at an internal pointer.
module peripheral_dbg_soc_osd_rr_arbiter
   import peripheral_dbg_soc_osd_timestamp_pkg::*;
#(
   parameter  int unsigned NREQ  = DEF_NREQ,
   localparam int unsigned IDX_W = idx_w(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic             enable,
   output logic [NREQ-1:0]  grant_c,
   output logic [IDX_W-1:0] grant_idx_c
);

   logic [IDX_W-1:0] ptr;
   logic             found;

   // First requester at or after ptr, wrapping modulo NREQ.
   always_comb begin : search
      int unsigned j;
      j           = 0;
      found       = 1'b0;
      grant_c     = '0;
      grant_idx_c = '0;
      if (enable) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr) + i) % NREQ;
            if (!found && req[IDX_W'(j)]) begin
               found                = 1'b1;
               grant_c[IDX_W'(j)]   = 1'b1;
               grant_idx_c          = IDX_W'(j);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (grant_idx_c == IDX_W'(NREQ - 1)) ? '0 : IDX_W'(grant_idx_c + 1'b1);
      end
   end

endmodule

// File: rtl/peripheral_dbg_soc_osd_timestamp.sv
// Free-running timestamp counter with synchronous active-high clear.
module peripheral_dbg_soc_osd_timestamp
   import peripheral_dbg_soc_osd_timestamp_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (enable) begin
         value <= WIDTH'(value + 1'b1);
      end
   end

endmodule

// File: rtl/peripheral_dbg_soc_osd_timestamp_ctrl.sv
// Run/stop/clear sequencing of the timestamp counter plus round-robin snapshot service.
module peripheral_dbg_soc_osd_timestamp_ctrl
   import peripheral_dbg_soc_osd_timestamp_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned NREQ       = DEF_NREQ,
   parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_run,
   input  logic                  cfg_clear,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic [WIDTH-1:0]      ts_value,
   output logic                  ts_enable,
   output logic                  ts_rst,
   output logic                  ts_overflow,
   peripheral_dbg_soc_osd_timestamp_ctrl_if.master bus
);

   localparam int unsigned ID_W = idx_w(NREQ);

   ts_ctrl_state_t        state_q, state_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic                  wrap_c;
   logic                  arb_enable_c;
   logic [ID_W-1:0]       grant_idx_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter enable is combinational so the counter advances in the same cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ts_enable = 1'b0;
      ts_rst    = 1'b0;
      unique case (state_q)
         CLEAR: begin
            ts_rst  = 1'b1;
            cnt_d   = '0;
            state_d = cfg_run ? RUN : STOP;
         end
         STOP: begin
            if (cfg_run) state_d = RUN;
         end
         RUN: begin
            if (cnt_q == cfg_prescale) begin
               ts_enable = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = PRESCALE_W'(cnt_q + 1'b1);
            end
            if (!cfg_run) state_d = STOP;
         end
         default: state_d = CLEAR;
      endcase
      // Clear overrides run/stop and suppresses any enable pulse this cycle.
      if (cfg_clear) begin
         ts_enable = 1'b0;
         state_d   = CLEAR;
      end
   end

   assign wrap_c = ts_enable && (ts_value == {WIDTH{1'b1}});

   always_ff @(posedge clk) begin
      if (!rst) begin
         ts_overflow <= 1'b0;
      end else if (state_q == CLEAR) begin
         ts_overflow <= 1'b0;
      end else if (wrap_c) begin
         ts_overflow <= 1'b1;
      end
   end

   // Grant only while the output slot is free and never during reset.
   assign arb_enable_c = rst && (!bus.snap_valid || bus.snap_ready);

   peripheral_dbg_soc_osd_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (bus.req_valid),
      .enable      (arb_enable_c),
      .grant_c     (bus.req_ready),
      .grant_idx_c (grant_idx_c)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.snap_valid <= 1'b0;
         bus.snap_id    <= '0;
         bus.snap_ts    <= '0;
      end else if (|bus.req_ready) begin
         bus.snap_valid <= 1'b1;
         bus.snap_id    <= grant_idx_c;
         bus.snap_ts    <= ts_value;
      end else if (bus.snap_ready) begin
         bus.snap_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_peripheral_dbg_soc_osd_timestamp_ctrl.sv
// Directed bench: controller with a 4-bit counter instance and four snapshot requesters.
module tb_peripheral_dbg_soc_osd_timestamp_ctrl;
   import peripheral_dbg_soc_osd_timestamp_pkg::*;

   localparam int unsigned WIDTH      = 4;
   localparam int unsigned NREQ       = 4;
   localparam int unsigned PRESCALE_W = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cfg_run;
   logic                  cfg_clear;
   logic [PRESCALE_W-1:0] cfg_prescale;
   logic [WIDTH-1:0]      ts_value;
   logic                  ts_enable;
   logic                  ts_rst;
   logic                  ts_overflow;

   int checks   = 0;
   int failures = 0;

   peripheral_dbg_soc_osd_timestamp_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   peripheral_dbg_soc_osd_timestamp_ctrl #(
      .WIDTH(WIDTH), .NREQ(NREQ), .PRESCALE_W(PRESCALE_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_run      (cfg_run),
      .cfg_clear    (cfg_clear),
      .cfg_prescale (cfg_prescale),
      .ts_value     (ts_value),
      .ts_enable    (ts_enable),
      .ts_rst       (ts_rst),
      .ts_overflow  (ts_overflow),
      .bus          (bus)
   );

   peripheral_dbg_soc_osd_timestamp #(.WIDTH(WIDTH)) u_ts (
      .clk    (clk),
      .rst    (ts_rst),
      .enable (ts_enable),
      .value  (ts_value)
   );

   always #5 clk = ~clk;

   // Advance to 2 time units after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_snap(input string tag, input logic v, input int id, input int ts);
      chk({tag, "_valid"}, 32'(bus.snap_valid), 32'(v));
      chk({tag, "_id"},    32'(bus.snap_id),    32'(id));
      chk({tag, "_ts"},    32'(bus.snap_ts),    32'(ts));
   endtask

   initial begin
      rst           = 1'b0;
      cfg_run       = 1'b1;
      cfg_clear     = 1'b0;
      cfg_prescale  = '0;
      bus.req_valid = '0;
      bus.snap_ready = 1'b0;
      repeat (3) cyc();
      #1;
      chk("rst_ts_rst", 32'(ts_rst), 32'd1);
      chk("rst_ts_en",  32'(ts_enable), 32'd0);
      chk("rst_ovf",    32'(ts_overflow), 32'd0);
      chk("rst_rdy",    32'(bus.req_ready), 32'd0);
      chk("rst_value",  32'(ts_value), 32'd0);
      chk_snap("rst_snap", 1'b0, 0, 0);
      // First cycle after release is still CLEAR.
      rst = 1'b1;
      #1;
      chk("rel_ts_rst", 32'(ts_rst), 32'd1);
      chk("rel_ts_en",  32'(ts_enable), 32'd0);
      cyc();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("p0_value",  32'(ts_value), 32'(k));
         chk("p0_ts_rst", 32'(ts_rst), 32'd0);
         chk("p0_en",     32'(ts_enable), 32'd1);
         cyc();
      end
      // Prescale 3: pulse every fourth RUN cycle.
      cfg_prescale = 8'd3;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (i == 0) chk("p3_start_value", 32'(ts_value), 32'd4);
         chk("p3_en", 32'(ts_enable), 32'(i % 4 == 3));
         cyc();
      end
      #1;
      chk("p3_end_value", 32'(ts_value), 32'd8);
      cyc();
      // Stop for five cycles mid-count, then resume: pulse after remaining two RUN cycles.
      for (int i = 0; i < 8; i++) begin
         cfg_run = (i < 5) ? 1'b0 : 1'b1;
         #1;
         chk("stop_en", 32'(ts_enable), 32'(i == 7));
         chk("stop_value", 32'(ts_value), 32'd8);
         cyc();
      end
      // Clear beats a pending enable pulse.
      cfg_prescale = '0;
      cfg_clear    = 1'b1;
      #1;
      chk("clr_value", 32'(ts_value), 32'd9);
      chk("clr_en",    32'(ts_enable), 32'd0);
      cyc();
      cfg_clear = 1'b0;
      #1;
      chk("clr_state_ts_rst", 32'(ts_rst), 32'd1);
      chk("clr_state_en",     32'(ts_enable), 32'd0);
      cyc();
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("ramp_value", 32'(ts_value), 32'(i));
         chk("ramp_ovf",   32'(ts_overflow), 32'd0);
         chk("ramp_en",    32'(ts_enable), 32'd1);
         cyc();
      end
      #1;
      chk("wrap_value", 32'(ts_value), 32'd0);
      chk("wrap_ovf",   32'(ts_overflow), 32'd1);
      cyc();
      cfg_clear = 1'b1;
      #1;
      chk("sticky_ovf",   32'(ts_overflow), 32'd1);
      chk("sticky_value", 32'(ts_value), 32'd1);
      cyc();
      cfg_clear = 1'b0;
      #1;
      chk("ovfclr_ts_rst", 32'(ts_rst), 32'd1);
      cyc();
      #1;
      chk("ovfclr_ovf",   32'(ts_overflow), 32'd0);
      chk("ovfclr_value", 32'(ts_value), 32'd0);
      repeat (15) cyc();
      // Clear in the same cycle as a wrap: overflow must stay low.
      cfg_clear = 1'b1;
      #1;
      chk("wrapclr_value", 32'(ts_value), 32'd15);
      chk("wrapclr_en",    32'(ts_enable), 32'd0);
      cyc();
      cfg_clear = 1'b0;
      #1;
      chk("wrapclr_ovf1", 32'(ts_overflow), 32'd0);
      cyc();
      // Round-robin over all four requesters with the consumer always ready.
      bus.req_valid  = 4'hF;
      bus.snap_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (i == 0) begin
            chk("wrapclr_ovf2",   32'(ts_overflow), 32'd0);
            chk("wrapclr_value2", 32'(ts_value), 32'd0);
         end
         chk("rr_rdy", 32'(bus.req_ready), 32'(1 << (i % 4)));
         if (i > 0) chk_snap("rr_snap", 1'b1, (i - 1) % 4, i - 1);
         cyc();
      end
      // Backpressure: no grants, outputs frozen.
      bus.snap_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_rdy", 32'(bus.req_ready), 32'd0);
         chk_snap("bp_snap", 1'b1, 0, 4);
         cyc();
      end
      bus.snap_ready = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(bus.req_ready), 32'b0010);
      chk_snap("bp_release_snap", 1'b1, 0, 4);
      cyc();
      #1;
      chk_snap("bp_next_snap", 1'b1, 1, 8);
      chk("bp_next_rdy", 32'(bus.req_ready), 32'b0100);
      cyc();
      bus.snap_ready = 1'b0;
      #1;
      chk_snap("pre_rst_snap", 1'b1, 2, 9);
      cyc();
      // Reset while a snapshot is pending.
      rst = 1'b0;
      #1;
      chk("in_rst_rdy", 32'(bus.req_ready), 32'd0);
      chk_snap("in_rst_snap", 1'b1, 2, 9);
      cyc();
      #1;
      chk_snap("mid_rst_snap", 1'b0, 0, 0);
      chk("mid_rst_ovf",    32'(ts_overflow), 32'd0);
      chk("mid_rst_en",     32'(ts_enable), 32'd0);
      chk("mid_rst_ts_rst", 32'(ts_rst), 32'd1);
      chk("mid_rst_rdy",    32'(bus.req_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("post_rst_rdy",    32'(bus.req_ready), 32'b0001);
      chk("post_rst_ts_rst", 32'(ts_rst), 32'd1);
      cyc();
      // Requester 1 asserts and drops while the slot is busy: pointer must not move.
      bus.snap_ready = 1'b0;
      bus.req_valid  = 4'b0010;
      #1;
      chk_snap("clear_snap", 1'b1, 0, 12);
      chk("drop_rdy1",  32'(bus.req_ready), 32'd0);
      chk("drop_value", 32'(ts_value), 32'd0);
      cyc();
      bus.req_valid = 4'b0000;
      #1;
      chk("drop_rdy2", 32'(bus.req_ready), 32'd0);
      chk_snap("drop_snap", 1'b1, 0, 12);
      cyc();
      bus.req_valid  = 4'b0011;
      bus.snap_ready = 1'b1;
      #1;
      chk("drop_ptr_rdy",  32'(bus.req_ready), 32'b0010);
      chk("drop_value2",   32'(ts_value), 32'd2);
      cyc();
      bus.req_valid = 4'b0000;
      #1;
      chk_snap("drop_after_snap", 1'b1, 1, 2);
      chk("idle_rdy", 32'(bus.req_ready), 32'd0);
      cyc();
      #1;
      chk("idle_valid", 32'(bus.snap_valid), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
